// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP  = 4;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset load, sequential step, redirect load.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Redirect load wins over the sequential step; arithmetic wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = align_word(target);
    end else if (inc) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding instruction read, valid/ready to decode,
// redirects from execute with discard of stale responses.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic         discard_q, discard_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instruction_q, instruction_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic [31:0]  pc;
  logic         redirect;
  logic         handshake;
  logic         capture;
  logic         pc_inc;

  // Event decode shared by next-state and datapath logic.
  always_comb begin
    redirect  = redirect_valid && (state_q != S_RESET);
    handshake = (state_q == S_HOLD) && instr_ready;
    capture   = (state_q == S_WAIT) && imem_rvalid && !discard_q && !redirect;
    pc_inc    = handshake && !redirect;
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (pc_inc),
    .load   (redirect),
    .target (redirect_target),
    .pc     (pc)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_RESET;
      discard_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instruction_q <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state logic; redirect outranks every other event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: state_d = redirect ? S_FETCH : S_WAIT;
      S_WAIT: begin
        if (redirect) begin
          state_d = imem_rvalid ? S_FETCH : S_WAIT;
        end else if (imem_rvalid) begin
          state_d = discard_q ? S_FETCH : S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || instr_ready) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // Discard flag, instruction capture and handshake counter.
  always_comb begin
    discard_d     = discard_q;
    instr_valid_d = instr_valid_q;
    instruction_d = instruction_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    if (state_q == S_WAIT) begin
      if (redirect) begin
        discard_d = !imem_rvalid;
      end else if (imem_rvalid) begin
        discard_d = 1'b0;
      end
    end
    if (capture) begin
      instr_valid_d = 1'b1;
      instruction_d = imem_rdata;
      instr_pc_d    = pc;
    end
    if (redirect || handshake) begin
      instr_valid_d = 1'b0;
    end
    if (handshake) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // Outputs. A redirect in S_FETCH withholds the request: memory accepts
  // requests without a grant, so issuing it would leave an untracked response.
  always_comb begin
    imem_req    = (state_q == S_FETCH) && !redirect_valid;
    imem_addr   = pc;
    instr_valid = instr_valid_q;
    instruction = instruction_q;
    instr_pc    = instr_pc_q;
    fetch_count = fetch_count_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run against a transaction-level PC/count model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] fetch_count;

  int n_tests;
  int n_fail;

  // Memory model state
  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] mem_addr;
  int unsigned mem_cnt;
  int unsigned mem_lat;
  bit          mem_pending;
  int          proto_errors;
  bit          use_fixed;
  logic [31:0] fixed_data;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: request seen mid-cycle is accepted at the next edge; data is
  // returned so the DUT samples it mem_lat edges after acceptance.
  always @(negedge clk) begin
    s_req  = imem_req;
    s_addr = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (s_req) begin
      if (mem_pending) proto_errors++;
      mem_pending = 1'b1;
      mem_cnt     = mem_lat;
      mem_addr    = s_addr;
    end
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = use_fixed ? fixed_data : mem_word(mem_addr);
        mem_pending = 1'b0;
      end
    end
  end

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic to_mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    repeat (6) to_edge();
    rst_n = 1'b1;
    to_edge();
    to_mid();
  endtask

  task automatic test_reset();
    repeat (3) to_edge();
    to_mid();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req act=%0h exp=0", imem_req); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid act=%0h exp=0", instr_valid); end
    n_tests++; if (instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr act=%h exp=00000013", instruction); end
    n_tests++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count act=%0d exp=0", fetch_count); end
    n_tests++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr act=%h exp=0", imem_addr); end
    to_edge();
    rst_n = 1'b1;
    to_edge();
    to_mid();
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL release_req act=%0h exp=1", imem_req); end
    n_tests++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL release_addr act=%h exp=0", imem_addr); end
  endtask

  task automatic test_sequential();
    mem_lat     = 1;
    use_fixed   = 1'b1;
    fixed_data  = 32'h0031_0093;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_req k=%0d act=%0h/%h exp=1/%h", k, imem_req, imem_addr, 32'(4 * k)); end
      to_edge(); to_mid();
      n_tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait k=%0d req=%0h valid=%0h exp=0/0", k, imem_req, instr_valid); end
      to_edge(); to_mid();
      n_tests++; if (instr_valid !== 1'b1 || instruction !== 32'h0031_0093 || instr_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_hold k=%0d act=%0h/%h/%h exp=1/00310093/%h", k, instr_valid, instruction, instr_pc, 32'(4 * k)); end
      to_edge(); to_mid();
      n_tests++; if (fetch_count !== 32'(k + 1)) begin n_fail++; $display("FAIL seq_count k=%0d act=%0d exp=%0d", k, fetch_count, k + 1); end
    end
  endtask

  task automatic test_backpressure();
    use_fixed = 1'b0;
    to_edge();
    instr_ready = 1'b0;
    to_edge(); to_mid();
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_hold i=%0d valid=%0h req=%0h exp=1/0", i, instr_valid, imem_req); end
      n_tests++; if (instruction !== mem_word(32'd12) || instr_pc !== 32'd12) begin n_fail++; $display("FAIL bp_stable i=%0d act=%h/%h exp=%h/0000000c", i, instruction, instr_pc, mem_word(32'd12)); end
      to_edge(); to_mid();
    end
    instr_ready = 1'b1;
    to_edge(); to_mid();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin n_fail++; $display("FAIL bp_next act=%0h/%h exp=1/00000010", imem_req, imem_addr); end
    n_tests++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL bp_count act=%0d exp=4", fetch_count); end
  endtask

  task automatic test_redirect_wait();
    bit seen;
    do_reset();
    use_fixed   = 1'b0;
    mem_lat     = 3;
    instr_ready = 1'b1;
    to_edge();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    to_edge();
    redirect_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      to_mid();
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_stale c=%0d valid=%0h exp=0", c, instr_valid); end
      if (imem_req === 1'b1) seen = 1'b1;
      else to_edge();
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rw_timeout req=%0h exp=1", imem_req); end
    n_tests++; if (imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rw_addr act=%h exp=00000100", imem_addr); end
    mem_lat = 1;
    to_edge(); to_edge(); to_mid();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instruction !== mem_word(32'h100)) begin n_fail++; $display("FAIL rw_hold act=%0h/%h/%h exp=1/00000100/%h", instr_valid, instr_pc, instruction, mem_word(32'h100)); end
    to_edge(); to_mid();
    n_tests++; if (fetch_count !== 32'd1 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL rw_after act=%0d/%h exp=1/00000104", fetch_count, imem_addr); end
    n_tests++; if (proto_errors !== 0) begin n_fail++; $display("FAIL rw_outstanding act=%0d exp=0", proto_errors); end
  endtask

  task automatic test_redirect_ready();
    do_reset();
    mem_lat     = 1;
    instr_ready = 1'b1;
    repeat (6) to_edge();
    to_mid();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin n_fail++; $display("FAIL rr_pc8 act=%0h/%h exp=1/00000008", imem_req, imem_addr); end
    to_edge();
    instr_ready = 1'b0;
    to_edge(); to_mid();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'd8 || fetch_count !== 32'd2) begin n_fail++; $display("FAIL rr_hold act=%0h/%h/%0d exp=1/00000008/2", instr_valid, instr_pc, fetch_count); end
    to_edge();
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    to_edge();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    to_mid();
    n_tests++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL rr_count act=%0d exp=3", fetch_count); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rr_next act=%0h/%h/%0h exp=1/00000040/0", imem_req, imem_addr, instr_valid); end
    to_edge(); to_edge(); to_mid();
    n_tests++; if (instr_pc !== 32'h40 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL rr_pc act=%h/%0h exp=00000040/1", instr_pc, instr_valid); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    use_fixed = 1'b0;
    to_edge();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    to_edge();
    redirect_valid = 1'b0;
    mem_lat        = 3;
    to_mid();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL riw_req act=%0h/%h exp=1/00000200", imem_req, imem_addr); end
    to_edge();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      to_edge(); to_mid();
      n_tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL riw_inreset c=%0d valid=%0h req=%0h exp=0/0", c, instr_valid, imem_req); end
    end
    n_tests++; if (instruction !== 32'h13 || fetch_count !== 32'd0) begin n_fail++; $display("FAIL riw_regs act=%h/%0d exp=00000013/0", instruction, fetch_count); end
    to_edge();
    rst_n   = 1'b1;
    mem_lat = 1;
    to_edge(); to_mid();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL riw_restart act=%0h/%h exp=1/0", imem_req, imem_addr); end
    to_edge(); to_edge(); to_mid();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instruction !== mem_word(32'd0)) begin n_fail++; $display("FAIL riw_fetch act=%0h/%h/%h exp=1/0/%h", instr_valid, instr_pc, instruction, mem_word(32'd0)); end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_lat = 1;
    to_edge();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    to_edge();
    redirect_valid = 1'b0;
    to_mid();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top act=%0h/%h exp=1/fffffffc", imem_req, imem_addr); end
    instr_ready = 1'b1;
    to_edge(); to_edge(); to_mid();
    n_tests++; if (instr_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc act=%h exp=fffffffc", instr_pc); end
    to_edge(); to_mid();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_next act=%0h/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    int unsigned idle;
    int unsigned max_idle;
    bit          prev_redir;
    bit          hs;
    int          errs0;
    do_reset();
    use_fixed  = 1'b0;
    exp_pc     = 32'd0;
    exp_cnt    = 32'd0;
    idle       = 0;
    max_idle   = 0;
    prev_redir = 1'b0;
    errs0      = proto_errors;
    for (int c = 0; c < 3000; c++) begin
      if (imem_req === 1'b1) begin
        n_tests++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL rnd_addr c=%0d act=%h exp=%h", c, imem_addr, exp_pc); end
      end
      if (instr_valid === 1'b1) begin
        n_tests++; if (instr_pc !== exp_pc || instruction !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_instr c=%0d act=%h/%h exp=%h/%h", c, instr_pc, instruction, exp_pc, mem_word(exp_pc)); end
      end
      if (prev_redir) begin
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush c=%0d valid=%0h exp=0", c, instr_valid); end
      end
      n_tests++; if (fetch_count !== exp_cnt) begin n_fail++; $display("FAIL rnd_count c=%0d act=%0d exp=%0d", c, fetch_count, exp_cnt); end
      if (imem_req !== 1'b1 && instr_valid !== 1'b1) idle++;
      else idle = 0;
      if (idle > max_idle) max_idle = idle;
      hs = (instr_valid === 1'b1) && instr_ready;
      if (hs) exp_cnt = exp_cnt + 32'd1;
      if (redirect_valid) exp_pc = redirect_target & ~32'h3;
      else if (hs) exp_pc = exp_pc + 32'd4;
      prev_redir = redirect_valid;
      to_edge();
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) redirect_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else redirect_target = $urandom;
      mem_lat = $urandom_range(1, 4);
      to_mid();
    end
    redirect_valid = 1'b0;
    n_tests++; if (proto_errors !== errs0) begin n_fail++; $display("FAIL rnd_outstanding act=%0d exp=%0d", proto_errors, errs0); end
    n_tests++; if (max_idle > 8) begin n_fail++; $display("FAIL rnd_progress idle=%0d exp<=8", max_idle); end
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    instr_ready     = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'd0;
    s_req           = 1'b0;
    s_addr          = 32'd0;
    mem_addr        = 32'd0;
    mem_cnt         = 0;
    mem_lat         = 1;
    mem_pending     = 1'b0;
    proto_errors    = 0;
    use_fixed       = 1'b0;
    fixed_data      = 32'd0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ready();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

endmodule
